execute_branch_resolve: RTL
===========================

EXECUTE_BRANCH_RESOLVE -- requirements
Module: execute_branch_resolve

Interface
REQ-001 SHALL have parameter P_RESET_VECTOR, default 32'h0, the value driven on oNEXT_ADDR after reset.
REQ-002 SHALL have ports: iCLOCK in 1 clock; inRESET in 1 asynchronous active-low reset; iRESET_SYNC in 1 synchronous clear.
REQ-003 SHALL have ports: iCTRL_HOLD in 1 freeze all state; iFLUSH_DONE in 1 fetch restart acknowledge.
REQ-004 SHALL have ports: iPREV_VALID in 1; oPREV_BUSY out 1; iPREV_BRANCH in 1 instruction is a conditional branch; iPREV_CC in 4 condition code; iPREV_PREDICT in 1 predicted taken; iPREV_PC in 32; iPREV_TARGET in 32.
REQ-005 SHALL have ports: iFLAG in 5 architectural flags from the flag register; iFLAG_FWD_VALID in 1; iFLAG_FWD in 5 flag value committing this cycle.
REQ-006 SHALL have ports: oNEXT_VALID out 1; iNEXT_BUSY in 1; oNEXT_TAKEN out 1; oNEXT_FLUSH out 1 mispredict; oNEXT_ADDR out 32 redirect address.

Function
REQ-007 SHALL use flag bit map: [0] Z, [1] S, [2] C, [3] O, [4] P.
REQ-008 SHALL use effective flags = iFLAG_FWD when iFLAG_FWD_VALID, else iFLAG (forwarding has priority).
REQ-009 SHALL evaluate cc: 0 always; 1 Z; 2 !Z; 3 S; 4 !S; 5 C; 6 !C; 7 O; 8 !O; 9 C&!Z; 10 !C|Z; 11 S==O; 12 S!=O; 13 !Z&(S==O); 14 Z|(S!=O); 15 P.
REQ-010 SHALL treat non-branch instructions as taken=0, flush=0, addr=iPREV_PC+4.
REQ-011 SHALL compute taken per REQ-009 for branches; addr = taken ? iPREV_TARGET : iPREV_PC+4 (32-bit wrap, no carry out); flush = taken XOR iPREV_PREDICT.
REQ-012 SHALL register results in a one-entry output stage; latency one cycle from accept to oNEXT_VALID.
REQ-013 SHALL accept when iPREV_VALID & !oPREV_BUSY & !iCTRL_HOLD & state==RUN.
REQ-014 SHALL drive oPREV_BUSY = (oNEXT_VALID & iNEXT_BUSY) | (state==FLUSH) | iCTRL_HOLD.
REQ-015 SHALL hold output entry stable while oNEXT_VALID & iNEXT_BUSY; entry retires when !iNEXT_BUSY; accept and retire in the same cycle SHALL replace the entry with no bubble.
REQ-016 SHALL implement FSM RUN/FLUSH: RUN->FLUSH when an accepted entry has flush=1; FLUSH->RUN on iFLUSH_DONE; in FLUSH all iPREV_VALID are discarded (not accepted, not stored).
REQ-017 SHALL, in FLUSH, still retire the pending flush entry downstream.
REQ-018 SHALL, when iCTRL_HOLD=1, freeze FSM and output entry regardless of other inputs; iFLUSH_DONE during hold is ignored.
REQ-019 SHALL give iRESET_SYNC priority over iCTRL_HOLD and all other inputs.
REQ-020 SHALL clear oNEXT_VALID when an entry retires with no new accept.

Reset
REQ-021 SHALL on inRESET low or iRESET_SYNC high set: state=RUN, oNEXT_VALID=0, oNEXT_TAKEN=0, oNEXT_FLUSH=0, oNEXT_ADDR=P_RESET_VECTOR.
REQ-022 SHALL drive oPREV_BUSY=0 in reset state unless iCTRL_HOLD=1.
REQ-023 SHALL, on reset asserted mid-FLUSH, return to RUN without waiting for iFLUSH_DONE.

Structure
REQ-024 SHALL place flag bit indices, cc encodings and FSM state encodings in the shared core package.
REQ-025 SHALL implement condition evaluation as combinational sub-module execute_branch_cond (cc, flags -> taken).
REQ-026 SHALL contain no other state than FSM and output entry.

Verification
REQ-027 SHALL test: iFLAG=5'h01, cc=1, branch, predict=0, PC=0x100, target=0x200 -> next cycle taken=1, flush=1, addr=0x200, then busy until iFLUSH_DONE.
REQ-028 SHALL test forwarding: iFLAG=5'h01, iFLAG_FWD_VALID=1, iFLAG_FWD=5'h00, cc=1 -> taken=0, addr=PC+4.
REQ-029 SHALL test backpressure: iNEXT_BUSY=1 for 3 cycles with second instruction pending -> oPREV_BUSY=1, output unchanged, both delivered in order without loss.
REQ-030 SHALL test wrap: non-branch PC=0xFFFFFFFC -> addr=0x00000000.
REQ-031 SHALL test all 16 cc against all 32 flag values -> taken matches REQ-009 table.
REQ-032 SHALL test inRESET low while in FLUSH with oNEXT_VALID=1 -> state RUN, oNEXT_VALID=0, oNEXT_ADDR=P_RESET_VECTOR.

Source files
------------

// File: rtl/execute_branch_resolve_pkg.sv
// Shared core definitions for branch resolution: flag bit positions,
// condition-code encodings and the resolve-stage FSM states.
`default_nettype none

package execute_branch_resolve_pkg;

    // Bit positions inside the 5-bit architectural flag vector
    localparam int FLAG_Z = 0;
    localparam int FLAG_S = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_O = 3;
    localparam int FLAG_P = 4;
    localparam int FLAG_W = 5;

    // Condition-code encodings
    localparam logic [3:0] CC_ALWAYS = 4'd0;
    localparam logic [3:0] CC_EQ     = 4'd1;
    localparam logic [3:0] CC_NE     = 4'd2;
    localparam logic [3:0] CC_MI     = 4'd3;
    localparam logic [3:0] CC_PL     = 4'd4;
    localparam logic [3:0] CC_CS     = 4'd5;
    localparam logic [3:0] CC_CC     = 4'd6;
    localparam logic [3:0] CC_VS     = 4'd7;
    localparam logic [3:0] CC_VC     = 4'd8;
    localparam logic [3:0] CC_HI     = 4'd9;
    localparam logic [3:0] CC_LS     = 4'd10;
    localparam logic [3:0] CC_GE     = 4'd11;
    localparam logic [3:0] CC_LT     = 4'd12;
    localparam logic [3:0] CC_GT     = 4'd13;
    localparam logic [3:0] CC_LE     = 4'd14;
    localparam logic [3:0] CC_PAR    = 4'd15;

    localparam logic [31:0] INSN_BYTES = 32'd4;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/execute_branch_resolve_cond.sv
// Combinational condition evaluator: decides whether a branch with the
// given condition code is taken under the supplied flags.
`default_nettype none

module execute_branch_cond
    import execute_branch_resolve_pkg::*;
(
    input  logic [3:0]       cc,
    input  logic [FLAG_W-1:0] flags,
    output logic             taken
);

    logic z, s, c, o, p;

    assign z = flags[FLAG_Z];
    assign s = flags[FLAG_S];
    assign c = flags[FLAG_C];
    assign o = flags[FLAG_O];
    assign p = flags[FLAG_P];

    always_comb begin
        taken = 1'b0;
        case (cc)
            CC_ALWAYS: taken = 1'b1;
            CC_EQ:     taken = z;
            CC_NE:     taken = !z;
            CC_MI:     taken = s;
            CC_PL:     taken = !s;
            CC_CS:     taken = c;
            CC_CC:     taken = !c;
            CC_VS:     taken = o;
            CC_VC:     taken = !o;
            CC_HI:     taken = c & !z;
            CC_LS:     taken = !c | z;
            CC_GE:     taken = (s == o);
            CC_LT:     taken = (s != o);
            CC_GT:     taken = !z & (s == o);
            CC_LE:     taken = z | (s != o);
            CC_PAR:    taken = p;
            default:   taken = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/execute_branch_resolve.sv
// Execute-stage branch resolver: evaluates the branch condition, produces the
// redirect address and mispredict flag, and stalls upstream until fetch restarts.
`default_nettype none

module execute_branch_resolve
    import execute_branch_resolve_pkg::*;
#(
    parameter logic [31:0] P_RESET_VECTOR = 32'h0
) (
    input  logic        iCLOCK,
    input  logic        inRESET,
    input  logic        iRESET_SYNC,
    input  logic        iCTRL_HOLD,
    input  logic        iFLUSH_DONE,
    input  logic        iPREV_VALID,
    output logic        oPREV_BUSY,
    input  logic        iPREV_BRANCH,
    input  logic [3:0]  iPREV_CC,
    input  logic        iPREV_PREDICT,
    input  logic [31:0] iPREV_PC,
    input  logic [31:0] iPREV_TARGET,
    input  logic [4:0]  iFLAG,
    input  logic        iFLAG_FWD_VALID,
    input  logic [4:0]  iFLAG_FWD,
    output logic        oNEXT_VALID,
    input  logic        iNEXT_BUSY,
    output logic        oNEXT_TAKEN,
    output logic        oNEXT_FLUSH,
    output logic [31:0] oNEXT_ADDR
);

    state_t      state, state_nxt;
    logic        out_valid, out_valid_nxt;
    logic        out_taken, out_taken_nxt;
    logic        out_flush, out_flush_nxt;
    logic [31:0] out_addr, out_addr_nxt;

    logic [4:0]  eff_flags;
    logic        cond_taken;
    logic        res_taken;
    logic        res_flush;
    logic [31:0] res_addr;
    logic [31:0] seq_addr;
    logic        accept;
    logic        retire;

    // A flag write committing this cycle is newer than the flag register
    assign eff_flags = iFLAG_FWD_VALID ? iFLAG_FWD : iFLAG;

    execute_branch_cond u_cond (
        .cc    (iPREV_CC),
        .flags (eff_flags),
        .taken (cond_taken)
    );

    assign seq_addr  = iPREV_PC + INSN_BYTES;
    assign res_taken = iPREV_BRANCH & cond_taken;
    assign res_flush = iPREV_BRANCH & (res_taken ^ iPREV_PREDICT);
    assign res_addr  = res_taken ? iPREV_TARGET : seq_addr;

    assign oPREV_BUSY = (out_valid & iNEXT_BUSY) | (state == ST_FLUSH) | iCTRL_HOLD;
    assign accept     = iPREV_VALID & !oPREV_BUSY & !iCTRL_HOLD & (state == ST_RUN);
    assign retire     = out_valid & !iNEXT_BUSY & !iCTRL_HOLD;

    always_comb begin
        state_nxt     = state;
        out_valid_nxt = out_valid;
        out_taken_nxt = out_taken;
        out_flush_nxt = out_flush;
        out_addr_nxt  = out_addr;

        if (!iCTRL_HOLD) begin
            // Accept wins over retire so a back-to-back stream has no bubble
            if (accept) begin
                out_valid_nxt = 1'b1;
                out_taken_nxt = res_taken;
                out_flush_nxt = res_flush;
                out_addr_nxt  = res_addr;
            end else if (retire) begin
                out_valid_nxt = 1'b0;
            end

            case (state)
                ST_RUN: begin
                    if (accept && res_flush) begin
                        state_nxt = ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (iFLUSH_DONE) begin
                        state_nxt = ST_RUN;
                    end
                end
                default: state_nxt = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            state     <= ST_RUN;
            out_valid <= 1'b0;
            out_taken <= 1'b0;
            out_flush <= 1'b0;
            out_addr  <= P_RESET_VECTOR;
        end else if (iRESET_SYNC) begin
            state     <= ST_RUN;
            out_valid <= 1'b0;
            out_taken <= 1'b0;
            out_flush <= 1'b0;
            out_addr  <= P_RESET_VECTOR;
        end else begin
            state     <= state_nxt;
            out_valid <= out_valid_nxt;
            out_taken <= out_taken_nxt;
            out_flush <= out_flush_nxt;
            out_addr  <= out_addr_nxt;
        end
    end

    assign oNEXT_VALID = out_valid;
    assign oNEXT_TAKEN = out_taken;
    assign oNEXT_FLUSH = out_flush;
    assign oNEXT_ADDR  = out_addr;

endmodule

`default_nettype wire
